// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - runs enabled CNN layer engines in order with timeout/abort
// A run walks idx from 0 to N_LAYERS, handshaking each enabled engine in turn.
module cnn_layer_sequencer #(
  parameter int N_LAYERS = 3,
  parameter int IDX_W    = 2,
  parameter int TO_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_LAYERS-1:0] layer_mask,
  input  logic [TO_W-1:0]     timeout_cycles,
  output logic [N_LAYERS-1:0] lyr_valid,
  input  logic [N_LAYERS-1:0] lyr_ready,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err_code,
  output logic [IDX_W-1:0]    err_layer,
  output logic [IDX_W-1:0]    cur_layer,
  output logic [31:0]         cycle_cnt
);

  localparam int NI = 2 ** IDX_W;

  typedef enum logic [1:0] {IDLE, SEEK, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [N_LAYERS-1:0] mask_q;
  logic [TO_W-1:0]     to_q;
  logic [TO_W-1:0]     wait_cnt;
  logic [IDX_W-1:0]    idx;
  logic [NI-1:0]       mask_ext;
  logic [NI-1:0]       ready_ext;
  logic [N_LAYERS-1:0] idx_onehot;
  logic                at_end;
  logic                sel_en;
  logic                sel_ready;
  logic                tmo;

  // Zero-padding lets idx == N_LAYERS index safely as a disabled, never-ready slot.
  assign mask_ext  = {{(NI-N_LAYERS){1'b0}}, mask_q};
  assign ready_ext = {{(NI-N_LAYERS){1'b0}}, lyr_ready};
  assign at_end    = (idx == IDX_W'(N_LAYERS));
  assign sel_en    = mask_ext[idx];
  assign sel_ready = ready_ext[idx];
  assign tmo       = (to_q != '0) && (wait_cnt == to_q - TO_W'(1));
  assign cur_layer = idx;

  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      idx_onehot[i] = (idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && !abort) state_nx = SEEK;
      SEEK: begin
        if (abort || at_end) state_nx = DONE;
        else if (sel_en)     state_nx = RUN;
      end
      RUN: begin
        if (abort)          state_nx = DONE;
        else if (sel_ready) state_nx = SEEK;
        else if (tmo)       state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      to_q      <= '0;
      wait_cnt  <= '0;
      idx       <= '0;
      lyr_valid <= '0;
      err_code  <= 2'b00;
      err_layer <= '0;
      cycle_cnt <= '0;
    end else begin
      if (state != IDLE && cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      case (state)
        IDLE: begin
          if (start && !abort) begin
            mask_q    <= layer_mask;
            to_q      <= timeout_cycles;
            idx       <= '0;
            err_code  <= 2'b00;
            cycle_cnt <= '0;
          end
        end
        SEEK: begin
          if (abort) begin
            err_code  <= 2'b10;
            err_layer <= idx;
            lyr_valid <= '0;
          end else if (!at_end) begin
            if (sel_en) begin
              lyr_valid <= idx_onehot;
              wait_cnt  <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        RUN: begin
          // Abort outranks ready, and ready outranks timeout.
          if (abort) begin
            err_code  <= 2'b10;
            err_layer <= idx;
            lyr_valid <= '0;
          end else if (sel_ready) begin
            lyr_valid <= '0;
            idx       <= idx + IDX_W'(1);
          end else if (tmo) begin
            err_code  <= 2'b01;
            err_layer <= idx;
            lyr_valid <= '0;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - scoreboard bench for cnn_layer_sequencer
// Each run pushes its modelled outcome; the entry is popped and compared on done.
module tb_cnn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  layer_mask;
  logic [15:0] timeout_cycles;
  logic [2:0]  lyr_valid;
  logic [2:0]  lyr_ready;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [1:0]  err_layer;
  logic [1:0]  cur_layer;
  logic [31:0] cycle_cnt;

  cnn_layer_sequencer #(.N_LAYERS(3), .IDX_W(2), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_mask(layer_mask), .timeout_cycles(timeout_cycles),
    .lyr_valid(lyr_valid), .lyr_ready(lyr_ready),
    .busy(busy), .done(done), .err_code(err_code), .err_layer(err_layer),
    .cur_layer(cur_layer), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int layer;
    int cc;
    int hi0;
    int hi1;
    int hi2;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rdy0_cyc;
  int   first_v2_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // dN = cycles of valid before the engine pulses ready, minus one; -1 = never answers.
  function automatic exp_t model(input logic [2:0] mask, input int to,
                                 input int d0, input int d1, input int d2, input bit ab0);
    exp_t e;
    int   d[3];
    int   hi[3];
    bit   fin;
    d = '{d0, d1, d2};
    hi = '{0, 0, 0};
    fin = 1'b0;
    e.code = 0;
    e.layer = 0;
    e.cc = 0;
    for (int i = 0; i < 3; i++) begin
      if (!fin) begin
        e.cc++;
        if (mask[i]) begin
          if (ab0 && i == 0) begin
            hi[i] = d[i] + 1;
            e.cc += hi[i] + 1;
            e.code = 2;
            e.layer = 0;
            fin = 1'b1;
          end else if (to != 0 && (d[i] < 0 || to <= d[i])) begin
            hi[i] = to;
            e.cc += to + 1;
            e.code = 1;
            e.layer = i;
            fin = 1'b1;
          end else begin
            hi[i] = d[i] + 1;
            e.cc += hi[i];
          end
        end
      end
    end
    if (!fin) e.cc += 2;
    e.hi0 = hi[0];
    e.hi1 = hi[1];
    e.hi2 = hi[2];
    return e;
  endfunction

  task automatic run_case(input string tag, input logic [2:0] mask, input int to,
                          input int d0, input int d1, input int d2,
                          input bit ab0, input bit spam, input bit rst_mid);
    exp_t       e;
    int         d[3];
    int         hi[3];
    logic [2:0] prev;
    int         last_rise, overlap, order_err, curl_err, ndone, stray, cyc;
    bit         seen_done;
    d = '{d0, d1, d2};
    hi = '{0, 0, 0};
    prev = '0;
    last_rise = -1;
    overlap = 0;
    order_err = 0;
    curl_err = 0;
    stray = 0;
    cyc = 0;
    seen_done = 1'b0;
    e = model(mask, to, d0, d1, d2, ab0);
    sb.push_back(e);
    layer_mask = mask;
    timeout_cycles = 16'(to);
    start = 1'b1;
    @(negedge clk);
    start = spam;
    if (spam) layer_mask = 3'b111;
    check({tag, ".busy_rise"}, busy, 1);
    check({tag, ".valid_lat"}, lyr_valid, 0);
    while (!seen_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (lyr_valid[i]) begin
          hi[i]++;
          if (!prev[i]) begin
            if (i <= last_rise) order_err++;
            last_rise = i;
            if (i == 2) first_v2_cyc = cyc;
          end
          if (cur_layer != 2'(i)) curl_err++;
        end
      end
      if ($countones(lyr_valid) > 1) overlap++;
      prev = lyr_valid;
      if (rst_mid && hi[1] == 3) begin
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".rst_valid"}, lyr_valid, 0);
        check({tag, ".rst_busy"}, busy, 0);
        check({tag, ".rst_done"}, done, 0);
        check({tag, ".rst_err"}, err_code, 0);
        check({tag, ".rst_cc"}, cycle_cnt, 0);
        check({tag, ".rst_cur"}, cur_layer, 0);
        e = sb.pop_front();
        lyr_ready = '0;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (done) begin
        seen_done = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          lyr_ready[i] = lyr_valid[i] && d[i] >= 0 && hi[i] == d[i] + 1;
        end
        if (lyr_ready[0]) rdy0_cyc = cyc;
        abort = ab0 && lyr_ready[0];
      end
    end
    e = sb.pop_front();
    if (!seen_done) begin
      check({tag, ".done_seen"}, 0, 1);
      lyr_ready = '0;
      abort = 1'b0;
      start = 1'b0;
      return;
    end
    check({tag, ".err_code"}, err_code, 64'(e.code));
    if (e.code != 0) check({tag, ".err_layer"}, err_layer, 64'(e.layer));
    lyr_ready = '0;
    abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_fall"}, busy, 0);
    check({tag, ".cycle_cnt"}, cycle_cnt, 64'(e.cc));
    check({tag, ".hi0"}, 64'(hi[0]), 64'(e.hi0));
    check({tag, ".hi1"}, 64'(hi[1]), 64'(e.hi1));
    check({tag, ".hi2"}, 64'(hi[2]), 64'(e.hi2));
    check({tag, ".overlap"}, 64'(overlap), 0);
    check({tag, ".order"}, 64'(order_err), 0);
    check({tag, ".cur_layer"}, 64'(curl_err), 0);
    ndone = 1;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
      if (lyr_valid != 0 || busy) stray++;
    end
    check({tag, ".done_count"}, 64'(ndone), 1);
    check({tag, ".idle_quiet"}, 64'(stray), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    layer_mask = '0;
    timeout_cycles = '0;
    lyr_ready = '0;
    rdy0_cyc = 0;
    first_v2_cyc = -100;
    #1;
    check("reset.valid", lyr_valid, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.err_code", err_code, 0);
    check("reset.err_layer", err_layer, 0);
    check("reset.cur_layer", cur_layer, 0);
    check("reset.cycle_cnt", cycle_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_case("all_on", 3'b111, 0, 5, 5, 5, 1'b0, 1'b0, 1'b0);
    first_v2_cyc = -100;
    run_case("skip1", 3'b101, 0, 4, 0, 3, 1'b0, 1'b0, 1'b0);
    check("skip1.v2_lat", 64'(first_v2_cyc - rdy0_cyc), 3);
    run_case("timeout", 3'b111, 8, 2, -1, 3, 1'b0, 1'b0, 1'b0);
    run_case("abort", 3'b111, 0, 3, 5, 5, 1'b1, 1'b0, 1'b0);
    run_case("mask0", 3'b000, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    run_case("ready_vs_to", 3'b001, 4, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    run_case("rst_mid", 3'b111, 0, 20, 20, 20, 1'b0, 1'b0, 1'b1);
    run_case("after_rst", 3'b111, 0, 2, 2, 2, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
